// File: rtl/invsqrt_result_collector.sv
// invsqrt_result_collector: captures the inverse-square-root result stream
// into a first-word-fall-through FIFO, counts a run of SAMPLES results and
// presents the buffered words on a ready/valid read port.
// Optional build macro: INVSQRT_FP_CHECK_EN enables the invalid-float check
// that drives bad_cnt/bad_flag (tied to 0 when the macro is undefined).
module invsqrt_result_collector #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 16,
  parameter int SAMPLES = 1000,
  parameter int CNT_W   = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              DataValid,
  input  logic [DATA_W-1:0] DataOut,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [CNT_W-1:0]  sample_cnt,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic              overflow,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bad_cnt,
  output logic              bad_flag
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SAMPLES - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic              empty, full, pop, push, drop, take, clear;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign rd_valid = !empty;
  assign rd_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign take  = (state == COLLECT) && DataValid;
  assign pop   = rd_valid && rd_ready;
  assign push  = take && (!full || pop);
  assign drop  = take && full && !pop;
  assign clear = ((state == IDLE) || (state == DONE)) && start;

  assign busy = (state == COLLECT) || (state == DRAIN);
  assign done = (state == DONE);

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= DataOut;
  end

  // FIFO pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Run statistics; cleared on entering COLLECT, saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_cnt <= '0;
      drop_cnt   <= '0;
      overflow   <= 1'b0;
    end else if (clear) begin
      sample_cnt <= '0;
      drop_cnt   <= '0;
      overflow   <= 1'b0;
    end else begin
      if (take && sample_cnt != CMAX) sample_cnt <= sample_cnt + 1'b1;
      if (drop) begin
        if (drop_cnt != CMAX) drop_cnt <= drop_cnt + 1'b1;
        overflow <= 1'b1;
      end
    end
  end

`ifdef INVSQRT_FP_CHECK_EN
  // Negative, zero/subnormal and Inf/NaN are not valid inverse square roots.
  logic [7:0] fp_exp;
  logic       bad_word;
  assign fp_exp   = DataOut[DATA_W-2 -: 8];
  assign bad_word = DataOut[DATA_W-1] || (fp_exp == 8'h00) || (fp_exp == 8'hFF);

  // Invalid-float tally over every captured or dropped word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bad_cnt  <= '0;
      bad_flag <= 1'b0;
    end else if (clear) begin
      bad_cnt  <= '0;
      bad_flag <= 1'b0;
    end else if (take && bad_word) begin
      if (bad_cnt != CMAX) bad_cnt <= bad_cnt + 1'b1;
      bad_flag <= 1'b1;
    end
  end
`else
  assign bad_cnt  = '0;
  assign bad_flag = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; the final sample is still pushed on the COLLECT exit edge.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = COLLECT;
      COLLECT: if (take && sample_cnt == LAST) state_nxt = DRAIN;
      DRAIN:   if (empty && !push) state_nxt = DONE;
      DONE:    if (start) state_nxt = COLLECT;
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_invsqrt_result_collector.sv
// Directed bench for invsqrt_result_collector (DEPTH=16, SAMPLES=40).
module tb_invsqrt_result_collector;
  localparam int DATA_W = 32, DEPTH = 16, SAMPLES = 40, CNT_W = 6;

  logic              clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic              DataValid = 1'b0, rd_ready = 1'b0;
  logic [DATA_W-1:0] DataOut = '0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid, overflow, busy, done, bad_flag;
  logic [CNT_W-1:0]  sample_cnt, drop_cnt, bad_cnt;

  int checks = 0, failures = 0;

  invsqrt_result_collector #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SAMPLES(SAMPLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .DataValid(DataValid), .DataOut(DataOut),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .sample_cnt(sample_cnt), .drop_cnt(drop_cnt), .overflow(overflow),
    .busy(busy), .done(done), .bad_cnt(bad_cnt), .bad_flag(bad_flag)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int n = 0; n < 20 && !done; n++) tick();
    chk(tag, 32'(done), 32'd1);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_cnts", 32'({sample_cnt, drop_cnt, bad_cnt}), 32'd0);
    chk("rst_flags", 32'({overflow, busy, done, bad_flag}), 32'd0);
    rst = 1'b0;
    tick();

    // DataValid in IDLE is ignored
    DataValid = 1'b1; DataOut = 32'h3F800000;
    tick();
    DataValid = 1'b0;
    chk("idle_sample_cnt", 32'(sample_cnt), 32'd0);
    chk("idle_rd_valid", 32'(rd_valid), 32'd0);

    // Run A: streaming with rd_ready=1, each word shows up right after its edge
    pulse_start();
    chk("a_busy", 32'(busy), 32'd1);
    rd_ready = 1'b1;
    for (int i = 0; i < SAMPLES; i++) begin
      DataValid = 1'b1; DataOut = 32'h3F800000 + 32'(i);
      tick();
      chk($sformatf("a_data%0d", i), rd_data, 32'h3F800000 + 32'(i));
    end
    DataValid = 1'b0;
    chk("a_sample_cnt", 32'(sample_cnt), 32'd40);
    chk("a_drain_busy", 32'({busy, done}), 32'b10);
    wait_done("a_done");
    chk("a_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("a_empty", 32'(rd_valid), 32'd0);

    // DataValid in DONE is ignored
    DataValid = 1'b1; DataOut = 32'h3F800055;
    tick();
    DataValid = 1'b0;
    chk("done_sample_cnt", 32'(sample_cnt), 32'd40);
    chk("done_rd_valid", 32'(rd_valid), 32'd0);

    // Run C: start from DONE clears counters; fill with rd_ready=0, 4 drops
    rd_ready = 1'b0;
    pulse_start();
    chk("c_cleared", 32'(sample_cnt), 32'd0);
    for (int i = 0; i < 20; i++) begin
      DataValid = 1'b1; DataOut = 32'h40000000 + 32'(i);
      tick();
    end
    chk("c_sample_cnt", 32'(sample_cnt), 32'd20);
    chk("c_drop_cnt", 32'(drop_cnt), 32'd4);
    chk("c_overflow", 32'(overflow), 32'd1);
    chk("c_head", rd_data, 32'h40000000);

    // Full FIFO with simultaneous push and pop: no drops, order kept
    rd_ready = 1'b1;
    for (int j = 0; j < 10; j++) begin
      chk($sformatf("d_head%0d", j), rd_data, 32'h40000000 + 32'(j));
      DataOut = 32'h40000000 + 32'(20 + j);
      tick();
    end
    DataValid = 1'b0;
    chk("d_drop_cnt", 32'(drop_cnt), 32'd4);
    chk("d_sample_cnt", 32'(sample_cnt), 32'd30);

    // Drain the 16 remaining words: W10..W15 then W20..W29
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("e_data%0d", k), rd_data,
          (k < 6) ? 32'h40000000 + 32'(10 + k) : 32'h40000000 + 32'(20 + k - 6));
      tick();
    end
    chk("e_empty", 32'(rd_valid), 32'd0);
    chk("e_still_collect", 32'({busy, done}), 32'b10);

    // Finish the run (10 more samples)
    for (int i = 0; i < 10; i++) begin
      DataValid = 1'b1; DataOut = 32'h40100000 + 32'(i);
      tick();
      chk($sformatf("f_data%0d", i), rd_data, 32'h40100000 + 32'(i));
    end
    DataValid = 1'b0;
    wait_done("f_done");
    chk("f_sample_cnt", 32'(sample_cnt), 32'd40);

    // Reset mid-COLLECT with 7 words buffered
    rd_ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 7; i++) begin
      DataValid = 1'b1; DataOut = 32'h3F000000 + 32'(i);
      tick();
    end
    DataValid = 1'b0;
    chk("g_pre_cnt", 32'(sample_cnt), 32'd7);
    chk("g_pre_valid", 32'(rd_valid), 32'd1);
    rst = 1'b1;
    tick();
    chk("g_rd_valid", 32'(rd_valid), 32'd0);
    chk("g_cnts", 32'({sample_cnt, drop_cnt, bad_cnt}), 32'd0);
    chk("g_flags", 32'({overflow, busy, done, bad_flag}), 32'd0);
    rst = 1'b0;
    tick();

    // Clean run after reset, including float-validity words
    rd_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < SAMPLES; i++) begin
      DataValid = 1'b1;
      case (i)
        0: DataOut = 32'hBF800000;
        1: DataOut = 32'h00000000;
        2: DataOut = 32'h7F800000;
        3: DataOut = 32'h3F000000;
        default: DataOut = 32'h3E800000 + 32'(i);
      endcase
      tick();
      if (i == 0) chk("h_first", rd_data, 32'hBF800000);
    end
    DataValid = 1'b0;
`ifdef INVSQRT_FP_CHECK_EN
    chk("h_bad_cnt", 32'(bad_cnt), 32'd3);
    chk("h_bad_flag", 32'(bad_flag), 32'd1);
`else
    chk("h_bad_cnt", 32'(bad_cnt), 32'd0);
    chk("h_bad_flag", 32'(bad_flag), 32'd0);
`endif
    wait_done("h_done");
    chk("h_sample_cnt", 32'(sample_cnt), 32'd40);
    chk("h_drop_cnt", 32'(drop_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
